// File: rtl/registro_desplazamiento_universal.sv
// Universal shift register: shift, rotate, parallel load, hold; registered serial out and saturating
// shifted-out counter. Define SALIDA_PARIDAD_EN to add the paridad_o output (XOR of q).

module registro_desplazamiento_universal_celda (
    input  logic [1:0] modo_i,
    input  logic       dir_i,
    input  logic       q_i,
    input  logic       bajo_i,
    input  logic       alto_i,
    input  logic       d_i,
    output logic       nxt_o
);
    // bajo_i feeds a left move (toward MSB), alto_i feeds a right move
    always_comb begin
        nxt_o = q_i;
        case (modo_i)
            2'b00, 2'b01: nxt_o = dir_i ? bajo_i : alto_i;
            2'b10:        nxt_o = d_i;
            default:      nxt_o = q_i;
        endcase
    end
endmodule

module registro_desplazamiento_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enb_i,
    input  logic [1:0]       modo_i,
    input  logic             dir_i,
    input  logic             s_in_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             s_out_o,
    output logic [CW-1:0]    cnt_o,
    output logic             vacio_o
`ifdef SALIDA_PARIDAD_EN
    ,
    output logic             paridad_o
`endif
);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fill_lo, fill_hi;

    // End-of-register fill bits: wrapped-around bit on rotate, serial input on shift
    assign fill_lo = (modo_i == 2'b01) ? q_q[WIDTH-1] : s_in_i;
    assign fill_hi = (modo_i == 2'b01) ? q_q[0]       : s_in_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bajo, alto;
        if (i == 0) begin : g_lo
            assign bajo = fill_lo;
        end else begin : g_lo_n
            assign bajo = q_q[i-1];
        end
        if (i == WIDTH - 1) begin : g_hi
            assign alto = fill_hi;
        end else begin : g_hi_n
            assign alto = q_q[i+1];
        end
        registro_desplazamiento_universal_celda u_celda (
            .modo_i (modo_i),
            .dir_i  (dir_i),
            .q_i    (q_q[i]),
            .bajo_i (bajo),
            .alto_i (alto),
            .d_i    (d_i[i]),
            .nxt_o  (q_d[i])
        );
    end

    always_comb begin
        s_out_d = s_out_q;
        cnt_d   = cnt_q;
        case (modo_i)
            2'b00: begin
                s_out_d = dir_i ? q_q[WIDTH-1] : q_q[0];
                cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
            end
            2'b01: s_out_d = dir_i ? q_q[WIDTH-1] : q_q[0];
            2'b10: begin
                s_out_d = 1'b0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_q     <= '0;
            s_out_q <= 1'b0;
            cnt_q   <= '0;
        end else if (enb_i) begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_o     = q_q;
    assign s_out_o = s_out_q;
    assign cnt_o   = cnt_q;
    assign vacio_o = (cnt_q == CNT_MAX);
`ifdef SALIDA_PARIDAD_EN
    assign paridad_o = ^q_q;
`endif
endmodule
